// File: rtl/otter_lsu_pkg.sv
// Shared types and constants for the OTTER load/store unit.
// It holds the FSM state encoding, the access-size codes and the default I/O base address.
package otter_lsu_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_LO,
        CAP_LO,
        RD_HI,
        CAP_HI,
        WR_LO,
        WR_HI,
        IO_OP,
        IO_CAP,
        RESP
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_X = 2'd3;

    localparam logic [31:0] DEFAULT_IO_BASE = 32'h1100_0000;

    // An illegal size reports four bytes; that request is rejected anyway.
    function automatic logic [2:0] sizeBytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/otter_lsu_if.sv
// Bundles the core request/response handshake and the memory port-2 bus of the load/store unit.
// The core drives master, the LSU uses slave, and the memory uses mem.
interface otter_lsu_if;

    logic        reqValid;
    logic        reqReady;
    logic        reqWe;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [1:0]  reqSize;
    logic        reqUns;

    logic        respValid;
    logic [31:0] respRdata;
    logic        respErr;

    logic [31:0] memAddr2;
    logic [31:0] memDin2;
    logic        memWrite2;
    logic        memRead2;
    logic [1:0]  memSize;
    logic        memSign;
    logic [31:0] memDout2;

    modport master (
        output reqValid, reqWe, reqAddr, reqWdata, reqSize, reqUns,
        input  reqReady, respValid, respRdata, respErr
    );

    modport slave (
        input  reqValid, reqWe, reqAddr, reqWdata, reqSize, reqUns, memDout2,
        output reqReady, respValid, respRdata, respErr,
        output memAddr2, memDin2, memWrite2, memRead2, memSize, memSign
    );

    modport mem (
        input  memAddr2, memDin2, memWrite2, memRead2, memSize, memSign,
        output memDout2
    );

endinterface

// File: rtl/otter_lsu_align.sv
// Combinational byte lane logic over the 64-bit {hi,lo} word window.
// It extracts and extends load data, and merges store data into the window.
module otter_lsu_align
    import otter_lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_window,
    output logic [31:0] o_rdata,
    output logic [63:0] o_merged
);

    logic [5:0]  w_shamt;
    logic [31:0] w_raw;
    logic [63:0] w_laneMask;
    logic [63:0] w_mask;
    logic [63:0] w_data;

    assign w_shamt = {1'b0, i_off, 3'b000};
    assign w_raw   = i_window[w_shamt +: 32];

    // Word loads ignore the unsigned flag.
    always_comb begin
        case (i_size)
            SZ_B:    o_rdata = {{24{~i_uns & w_raw[7]}}, w_raw[7:0]};
            SZ_H:    o_rdata = {{16{~i_uns & w_raw[15]}}, w_raw[15:0]};
            default: o_rdata = w_raw;
        endcase
    end

    always_comb begin
        case (i_size)
            SZ_B:    w_laneMask = 64'h0000_0000_0000_00FF;
            SZ_H:    w_laneMask = 64'h0000_0000_0000_FFFF;
            default: w_laneMask = 64'h0000_0000_FFFF_FFFF;
        endcase
    end

    assign w_mask   = w_laneMask << w_shamt;
    assign w_data   = {32'h0, i_wdata} << w_shamt;
    assign o_merged = (i_window & ~w_mask) | (w_data & w_mask);

endmodule

// File: rtl/otter_lsu.sv
// OTTER load/store unit: converts byte, half and word requests into aligned word traffic on memory port 2.
// Stores use read-modify-write, and accesses that cross a word boundary are split into two word operations.
module otter_lsu
    import otter_lsu_pkg::*;
#(
    parameter logic [31:0] IO_BASE = DEFAULT_IO_BASE
)
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    otter_lsu_if.slave  bus
);

    lsu_state_t  r_state;
    logic        r_we;
    logic        r_uns;
    logic        r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_wLo;
    logic [31:0] r_wHi;
    logic [31:0] r_rdata;

    logic [1:0]  w_reqOff;
    logic [31:0] w_reqLo;
    logic [31:0] w_reqHi;
    logic        w_reqSpan;
    logic        w_reqIo;
    logic        w_reqErr;

    logic [31:0] w_lo;
    logic [31:0] w_hi;
    logic        w_span;
    logic [63:0] w_window;
    logic [31:0] w_loadData;
    logic [63:0] w_merged;

    assign w_reqOff  = bus.reqAddr[1:0];
    assign w_reqLo   = {bus.reqAddr[31:2], 2'b00};
    assign w_reqHi   = w_reqLo + 32'd4;
    assign w_reqSpan = ({1'b0, w_reqOff} + sizeBytes(bus.reqSize)) > 3'd4;
    assign w_reqIo   = w_reqLo >= IO_BASE;
    assign w_reqErr  = (bus.reqSize == SZ_X)
                     || (w_reqIo && ((w_reqOff != 2'd0) || (bus.reqSize != SZ_W)))
                     || (w_reqSpan && !w_reqIo && (w_reqHi >= IO_BASE));

    assign w_lo   = {r_addr[31:2], 2'b00};
    assign w_hi   = w_lo + 32'd4;
    assign w_span = ({1'b0, r_addr[1:0]} + sizeBytes(r_size)) > 3'd4;

    // In a capture state, the word arriving from memory takes the place of its register.
    // This lets the response and the store merge be formed in the same cycle.
    always_comb begin
        case (r_state)
            CAP_LO:  w_window = {r_wHi, bus.memDout2};
            CAP_HI:  w_window = {bus.memDout2, r_wLo};
            default: w_window = {r_wHi, r_wLo};
        endcase
    end

    otter_lsu_align u_align (
        .i_off    (r_addr[1:0]),
        .i_size   (r_size),
        .i_uns    (r_uns),
        .i_wdata  (r_wdata),
        .i_window (w_window),
        .o_rdata  (w_loadData),
        .o_merged (w_merged)
    );

    // Memory strobes, address and write data come only from registered state.
    // The address is held steady across each read/capture pair for the memory's I/O output mux.
    always_comb begin
        bus.memRead2  = 1'b0;
        bus.memWrite2 = 1'b0;
        bus.memAddr2  = 32'h0;
        bus.memDin2   = 32'h0;
        case (r_state)
            RD_LO:  begin bus.memRead2 = 1'b1; bus.memAddr2 = w_lo; end
            CAP_LO: bus.memAddr2 = w_lo;
            RD_HI:  begin bus.memRead2 = 1'b1; bus.memAddr2 = w_hi; end
            CAP_HI: bus.memAddr2 = w_hi;
            WR_LO:  begin bus.memWrite2 = 1'b1; bus.memAddr2 = w_lo; bus.memDin2 = w_merged[31:0]; end
            WR_HI:  begin bus.memWrite2 = 1'b1; bus.memAddr2 = w_hi; bus.memDin2 = w_merged[63:32]; end
            IO_OP:  begin
                bus.memAddr2  = r_addr;
                bus.memRead2  = ~r_we;
                bus.memWrite2 = r_we;
                bus.memDin2   = r_we ? r_wdata : 32'h0;
            end
            IO_CAP: bus.memAddr2 = r_addr;
            default: ;
        endcase
    end

    assign bus.reqReady  = (r_state == IDLE);
    assign bus.respValid = (r_state == RESP);
    assign bus.respErr   = r_err;
    assign bus.respRdata = r_rdata;
    assign bus.memSize   = SZ_W;
    assign bus.memSign   = 1'b0;

    // The request is latched on accept, and the FSM then walks the fixed word sequence for its class.
    // The error flag and load data are only non-zero while RESP is the current state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= SZ_B;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wLo   <= 32'h0;
            r_wHi   <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.reqValid) begin
                        r_we    <= bus.reqWe;
                        r_uns   <= bus.reqUns;
                        r_size  <= bus.reqSize;
                        r_addr  <= bus.reqAddr;
                        r_wdata <= bus.reqWdata;
                        if (w_reqErr) begin
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end else if (w_reqIo) begin
                            r_state <= IO_OP;
                        end else begin
                            r_state <= RD_LO;
                        end
                    end
                end
                RD_LO:  r_state <= CAP_LO;
                CAP_LO: begin
                    r_wLo <= bus.memDout2;
                    if (w_span) begin
                        r_state <= RD_HI;
                    end else if (r_we) begin
                        r_state <= WR_LO;
                    end else begin
                        r_rdata <= w_loadData;
                        r_state <= RESP;
                    end
                end
                RD_HI:  r_state <= CAP_HI;
                CAP_HI: begin
                    r_wHi <= bus.memDout2;
                    if (r_we) begin
                        r_state <= WR_LO;
                    end else begin
                        r_rdata <= w_loadData;
                        r_state <= RESP;
                    end
                end
                WR_LO:  r_state <= w_span ? WR_HI : RESP;
                WR_HI:  r_state <= RESP;
                IO_OP:  r_state <= r_we ? RESP : IO_CAP;
                IO_CAP: begin
                    r_rdata <= bus.memDout2;
                    r_state <= RESP;
                end
                RESP: begin
                    r_err   <= 1'b0;
                    r_rdata <= 32'h0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_otter_lsu.sv
// Self-checking bench for otter_lsu: a word-array memory model on port 2 and a byte-level reference model.
// The stimulus is a set of directed cases followed by random requests.
module tb_otter_lsu;

    localparam logic [31:0] IO_BASE_TB = 32'h1100_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    otter_lsu_if bus();

    otter_lsu #(.IO_BASE(IO_BASE_TB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    logic [31:0] mem    [0:255];
    logic [31:0] refRam [0:255];
    logic [31:0] ioIn = 32'h0;
    logic [31:0] ioWrAddr = 32'h0;
    logic [31:0] ioWrData = 32'h0;
    int readCount = 0;
    int writeCount = 0;
    int ioWrCount = 0;
    int vectorCount = 0;
    int missCount = 0;

    function automatic logic [31:0] initWord(input int i);
        logic [31:0] w;
        w = 32'(i + 1) * 32'h9E37_79B9;
        return w ^ 32'h5A5A_0000;
    endfunction

    // Synchronous word memory: read data appears the cycle after the strobe.
    // Addresses at or above the I/O base go to the I/O buffers instead of RAM.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = initWord(i);
        bus.memDout2 <= 32'h0;
        forever begin
            @(posedge clk);
            if (bus.memWrite2) begin
                writeCount++;
                if (bus.memAddr2 >= IO_BASE_TB) begin
                    ioWrCount++;
                    ioWrAddr = bus.memAddr2;
                    ioWrData = bus.memDin2;
                end else begin
                    mem[bus.memAddr2[9:2]] = bus.memDin2;
                end
            end
            if (bus.memRead2) begin
                readCount++;
                bus.memDout2 <= (bus.memAddr2 >= IO_BASE_TB) ? ioIn : mem[bus.memAddr2[9:2]];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] refByte(input logic [31:0] a);
        logic [31:0] w;
        w = refRam[a[9:2]];
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] addr, input int n, input bit uns);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(refByte(addr + 32'(i))) << (8 * i));
        if (n < 4 && !uns && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic refStore(input logic [31:0] addr, input int n, input logic [31:0] wdata);
        logic [31:0] a;
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            w = refRam[a[9:2]];
            w[{a[1:0], 3'b000} +: 8] = wdata[8 * i +: 8];
            refRam[a[9:2]] = w;
        end
    endtask

    // Runs one request and checks latency, error flag, data and the strobe counts against the model.
    task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input bit uns, output logic [31:0] gotRdata);
        int n, off, expLat, expReads, expWrites, rd0, wr0, io0, lat;
        bit span, isIo, isErr, done;
        logic [31:0] lo, hi, expRdata;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
        lo = {addr[31:2], 2'b00};
        hi = lo + 32'd4;
        span = (off + n) > 4;
        isIo = lo >= IO_BASE_TB;
        isErr = (size == 2'd3) || (isIo && (off != 0 || size != 2'd2)) || (span && !isIo && hi >= IO_BASE_TB);
        if (isErr) begin
            expLat = 1; expReads = 0; expWrites = 0; expRdata = 32'h0;
        end else if (isIo) begin
            expLat = we ? 2 : 3; expReads = we ? 0 : 1; expWrites = we ? 1 : 0;
            expRdata = we ? 32'h0 : ioIn;
        end else begin
            expLat = we ? (span ? 7 : 4) : (span ? 5 : 3);
            expReads = span ? 2 : 1;
            expWrites = we ? (span ? 2 : 1) : 0;
            expRdata = we ? 32'h0 : refLoad(addr, n, uns);
        end
        gotRdata = 32'h0;
        @(negedge clk);
        for (int k = 0; k < 20 && !bus.reqReady; k++) @(negedge clk);
        if (!bus.reqReady) begin
            checkOutput("readyTimeout", 32'(bus.reqReady), 32'h1);
            return;
        end
        rd0 = readCount; wr0 = writeCount; io0 = ioWrCount;
        bus.reqWe = we; bus.reqAddr = addr; bus.reqWdata = wdata;
        bus.reqSize = size; bus.reqUns = uns; bus.reqValid = 1'b1;
        @(posedge clk);
        done = 1'b0;
        lat = 0;
        for (int c = 1; c <= 12 && !done; c++) begin
            @(negedge clk);
            bus.reqValid = 1'b0;
            if (bus.respValid) begin
                done = 1'b1;
                lat = c;
            end
        end
        if (!done) begin
            checkOutput("respTimeout", 32'h0, 32'h1);
            return;
        end
        gotRdata = bus.respRdata;
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("respErr", 32'(bus.respErr), 32'(isErr));
        checkOutput("respRdata", bus.respRdata, expRdata);
        checkOutput("readStrobes", 32'(readCount - rd0), 32'(expReads));
        checkOutput("writeStrobes", 32'(writeCount - wr0), 32'(expWrites));
        if (!isErr && isIo && we) begin
            checkOutput("ioWrCount", 32'(ioWrCount - io0), 32'h1);
            checkOutput("ioWrAddr", ioWrAddr, addr);
            checkOutput("ioWrData", ioWrData, wdata);
        end
        if (!isErr && !isIo && we) refStore(addr, n, wdata);
    endtask

    initial begin
        logic [31:0] r, rnd, addr, wdata;
        logic [1:0] size;
        bit we, uns;
        int wr0, bad;

        for (int i = 0; i < 256; i++) refRam[i] = initWord(i);
        bus.reqValid = 1'b0; bus.reqWe = 1'b0; bus.reqAddr = 32'h0;
        bus.reqWdata = 32'h0; bus.reqSize = 2'd0; bus.reqUns = 1'b0;

        #12;
        checkOutput("rstReady", 32'(bus.reqReady), 32'h1);
        checkOutput("rstStrobes", {30'h0, bus.memRead2, bus.memWrite2}, 32'h0);
        checkOutput("rstResp", {30'h0, bus.respValid, bus.respErr}, 32'h0);
        checkOutput("rstRdata", bus.respRdata, 32'h0);
        checkOutput("rstAddr", bus.memAddr2, 32'h0);
        checkOutput("rstDin", bus.memDin2, 32'h0);
        checkOutput("memSizeSign", {29'h0, bus.memSize, bus.memSign}, 32'h4);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, r);
        applyStimulus(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, r);
        checkOutput("lwDeadbeef", r, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, r);
        checkOutput("lbSigned", r, 32'hFFFF_FFDE);
        applyStimulus(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, r);
        checkOutput("lbUnsigned", r, 32'h0000_00DE);

        applyStimulus(1'b1, 32'h100, 32'h1122_3344, 2'd2, 1'b0, r);
        applyStimulus(1'b1, 32'h104, 32'h5566_7788, 2'd2, 1'b0, r);
        applyStimulus(1'b1, 32'h103, 32'hFFFF_1234, 2'd1, 1'b0, r);
        applyStimulus(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, r);
        checkOutput("shSpanLo", r, 32'h3422_3344);
        applyStimulus(1'b0, 32'h104, 32'h0, 2'd2, 1'b0, r);
        checkOutput("shSpanHi", r, 32'h5566_7712);

        applyStimulus(1'b1, 32'h1100_0020, 32'hCAFE_F00D, 2'd2, 1'b0, r);
        ioIn = 32'hA5A5_A5A5;
        applyStimulus(1'b0, 32'h1100_0000, 32'h0, 2'd2, 1'b0, r);
        checkOutput("ioLoad", r, 32'hA5A5_A5A5);

        applyStimulus(1'b0, 32'h200, 32'h0, 2'd3, 1'b0, r);
        applyStimulus(1'b0, 32'h1100_0001, 32'h0, 2'd1, 1'b0, r);
        applyStimulus(1'b0, 32'h10FF_FFFE, 32'h0, 2'd2, 1'b0, r);

        for (int t = 0; t < 300; t++) begin
            rnd = $urandom_range(0, 9);
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wdata = $urandom;
            ioIn = $urandom;
            rnd = $urandom_range(0, 2);
            size = rnd[1:0];
            addr = $urandom_range(32'h100, 32'h17F);
            rnd = $urandom_range(0, 9);
            if (rnd == 7) begin
                addr = IO_BASE_TB + ($urandom_range(0, 63) << 2);
                size = 2'd2;
            end else if (rnd == 8) begin
                rnd = $urandom_range(0, 2);
                if (rnd == 0) begin
                    size = 2'd3;
                end else if (rnd == 1) begin
                    addr = IO_BASE_TB + $urandom_range(0, 255);
                    rnd = $urandom_range(0, 1);
                    size = rnd[1:0];
                end else begin
                    addr = 32'h10FF_FFFC + $urandom_range(1, 3);
                    size = 2'd2;
                end
            end
            applyStimulus(we, addr, wdata, size, uns, r);
        end

        // Reset lands in CAP_HI of a spanning store, before any write is issued.
        @(negedge clk);
        wr0 = writeCount;
        bus.reqWe = 1'b1; bus.reqAddr = 32'h10D; bus.reqWdata = 32'h0BAD_F00D;
        bus.reqSize = 2'd2; bus.reqUns = 1'b0; bus.reqValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.reqValid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRstStrobes", {30'h0, bus.memRead2, bus.memWrite2}, 32'h0);
        checkOutput("midRstResp", {30'h0, bus.respValid, bus.respErr}, 32'h0);
        checkOutput("midRstAddrDin", bus.memAddr2 | bus.memDin2 | bus.respRdata, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("noWriteAfterReset", 32'(writeCount - wr0), 32'h0);
        applyStimulus(1'b0, 32'h10D, 32'h0, 2'd2, 1'b0, r);
        applyStimulus(1'b0, 32'h10E, 32'h0, 2'd1, 1'b1, r);

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== refRam[i]) bad++;
        checkOutput("ramSweep", 32'(bad), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL globalTimeout: observed running, expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
